// File: rtl/datapath_control_fsm.sv
// Multicycle IDLE/DECODE/EXEC control unit for the 64-bit load/store/add/sub datapath.
// Controls decode from the latched instruction word, so they hold their values while idle.
module datapath_control_fsm #(
  parameter int COUNT_W = 32
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [31:0]        instr,
  input  logic               instr_valid,
  output logic               instr_ready,
  output logic [4:0]         readRegister1,
  output logic [4:0]         readRegister2,
  output logic [4:0]         writeRegister,
  output logic [63:0]        immediate,
  output logic               writeEnable_Registers,
  output logic               writeEnable_DataMemory,
  output logic               muxSelect_SumVsReadData,
  output logic               muxSelect_ImmVsDataout2,
  output logic               SumOrSub,
  output logic               illegalInstr,
  output logic [COUNT_W-1:0] retiredCount
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_DECODE,
    S_EXEC
  } state_t;

  state_t             r_state;
  state_t             w_next;
  logic [31:0]        r_instr;
  logic               r_illegal;
  logic [COUNT_W-1:0] r_count;

  logic [6:0] w_opcode;
  logic [2:0] w_funct3;
  logic [6:0] w_funct7;
  logic [4:0] w_rd;
  logic [4:0] w_rs1;
  logic [4:0] w_rs2;
  logic       w_is_load;
  logic       w_is_store;
  logic       w_is_alu;
  logic       w_legal;
  logic       w_accept;
  logic       w_exec;

  assign w_opcode = r_instr[6:0];
  assign w_rd     = r_instr[11:7];
  assign w_funct3 = r_instr[14:12];
  assign w_rs1    = r_instr[19:15];
  assign w_rs2    = r_instr[24:20];
  assign w_funct7 = r_instr[31:25];

  assign w_is_load  = (w_opcode == 7'b0000011) && (w_funct3 == 3'b010 || w_funct3 == 3'b011);
  assign w_is_store = (w_opcode == 7'b0100011) && (w_funct3 == 3'b010 || w_funct3 == 3'b011);
  assign w_is_alu   = (w_opcode == 7'b0110011) && (w_funct3 == 3'b000) &&
                      (w_funct7 == 7'b0000000 || w_funct7 == 7'b0100000);
  assign w_legal    = w_is_load || w_is_store || w_is_alu;

  assign instr_ready = (r_state == S_IDLE);
  assign w_accept    = instr_ready && instr_valid;
  assign w_exec      = (r_state == S_EXEC);

  // NOTE: sequential state uses non-blocking (<=) so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // NOTE: every signal driven here gets a default first, so no path infers a latch.
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:   if (w_accept) w_next = S_DECODE;
      S_DECODE: w_next = S_EXEC;
      S_EXEC:   w_next = S_IDLE;
      default:  w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_instr   <= '0;
      r_illegal <= 1'b0;
      r_count   <= '0;
    end else begin
      if (w_accept) r_instr <= instr;
      if (r_state == S_DECODE && !w_legal) r_illegal <= 1'b1;
      if (w_exec && w_legal) r_count <= r_count + 1'b1;
    end
  end

  // Clearing r_instr on reset makes every control output fall to zero at once.
  always_comb begin
    readRegister1           = '0;
    readRegister2           = '0;
    writeRegister           = '0;
    immediate               = '0;
    writeEnable_Registers   = 1'b0;
    writeEnable_DataMemory  = 1'b0;
    muxSelect_SumVsReadData = 1'b0;
    muxSelect_ImmVsDataout2 = 1'b0;
    SumOrSub                = 1'b0;
    if (w_is_load) begin
      readRegister1         = w_rs1;
      writeRegister         = w_rd;
      immediate             = {{52{r_instr[31]}}, r_instr[31:20]};
      writeEnable_Registers = w_exec && (w_rd != 5'd0);
    end else if (w_is_store) begin
      readRegister1          = w_rs1;
      readRegister2          = w_rs2;
      immediate              = {{52{r_instr[31]}}, r_instr[31:25], r_instr[11:7]};
      writeEnable_DataMemory = w_exec;
    end else if (w_is_alu) begin
      readRegister1           = w_rs1;
      readRegister2           = w_rs2;
      writeRegister           = w_rd;
      muxSelect_SumVsReadData = 1'b1;
      muxSelect_ImmVsDataout2 = 1'b1;
      SumOrSub                = w_funct7[5];
      writeEnable_Registers   = w_exec && (w_rd != 5'd0);
    end
  end

  assign illegalInstr = r_illegal;
  assign retiredCount = r_count;

endmodule

// File: tb/tb_datapath_control_fsm.sv
// Bench for datapath_control_fsm: drives instruction words, models the load/store/add/sub
// datapath behaviourally, and compares controls against a decode model built from field rules.
module tb_datapath_control_fsm;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] instr = '0;
  logic        instr_valid = 1'b0;
  logic        instr_ready;
  logic [4:0]  readRegister1, readRegister2, writeRegister;
  logic [63:0] immediate;
  logic        writeEnable_Registers, writeEnable_DataMemory;
  logic        muxSelect_SumVsReadData, muxSelect_ImmVsDataout2, SumOrSub;
  logic        illegalInstr;
  logic [31:0] retiredCount;

  int n_checks = 0;
  int n_pass   = 0;
  int unsigned exp_count = 0;
  logic exp_illegal = 1'b0;

  datapath_control_fsm #(.COUNT_W(32)) dut (
    .clk(clk), .rst_n(rst_n), .instr(instr), .instr_valid(instr_valid),
    .instr_ready(instr_ready), .readRegister1(readRegister1), .readRegister2(readRegister2),
    .writeRegister(writeRegister), .immediate(immediate),
    .writeEnable_Registers(writeEnable_Registers), .writeEnable_DataMemory(writeEnable_DataMemory),
    .muxSelect_SumVsReadData(muxSelect_SumVsReadData), .muxSelect_ImmVsDataout2(muxSelect_ImmVsDataout2),
    .SumOrSub(SumOrSub), .illegalInstr(illegalInstr), .retiredCount(retiredCount)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Behavioural datapath steered by the unit's controls.
  logic [63:0] regs [32] = '{default: 64'd0};
  logic [63:0] mem  [32] = '{0: 64'd8, 1: 64'd6, 2: 64'd16, default: 64'd0};
  logic [63:0] dp_a, dp_b, dp_sum, dp_wb;
  always_comb begin
    dp_a   = regs[readRegister1];
    dp_b   = muxSelect_ImmVsDataout2 ? regs[readRegister2] : immediate;
    dp_sum = SumOrSub ? dp_a - dp_b : dp_a + dp_b;
    dp_wb  = muxSelect_SumVsReadData ? dp_sum : mem[dp_sum[7:3]];
  end
  always @(posedge clk) begin
    if (writeEnable_Registers && writeRegister != 5'd0) regs[writeRegister] <= dp_wb;
    if (writeEnable_DataMemory) mem[dp_sum[7:3]] <= regs[readRegister2];
  end

  typedef struct packed {
    logic [4:0]  rr1, rr2, wr;
    logic [63:0] imm;
    logic        m_sum, m_b, sub;
    logic        we_r, we_m, legal;
  } exp_t;

  function automatic logic [63:0] sext12(input int unsigned v);
    longint s;
    s = (v >= 2048) ? longint'(v) - 4096 : longint'(v);
    return 64'(s);
  endfunction

  function automatic exp_t model(input logic [31:0] w);
    exp_t e;
    int unsigned op, f3, f7, rd, rs1, rs2;
    op  = w % 128;
    rd  = (w >> 7) % 32;
    f3  = (w >> 12) % 8;
    rs1 = (w >> 15) % 32;
    rs2 = (w >> 20) % 32;
    f7  = w >> 25;
    e = '0;
    if (op == 3 && (f3 == 2 || f3 == 3)) begin
      e.rr1 = 5'(rs1); e.wr = 5'(rd); e.imm = sext12(w >> 20);
      e.we_r = (rd != 0); e.legal = 1'b1;
    end else if (op == 35 && (f3 == 2 || f3 == 3)) begin
      e.rr1 = 5'(rs1); e.rr2 = 5'(rs2); e.imm = sext12(f7 * 32 + rd);
      e.we_m = 1'b1; e.legal = 1'b1;
    end else if (op == 51 && f3 == 0 && (f7 == 0 || f7 == 32)) begin
      e.rr1 = 5'(rs1); e.rr2 = 5'(rs2); e.wr = 5'(rd);
      e.m_sum = 1'b1; e.m_b = 1'b1; e.sub = (f7 == 32);
      e.we_r = (rd != 0); e.legal = 1'b1;
    end
    return e;
  endfunction

  function automatic logic [81:0] exp_ctl(input exp_t e);
    return {e.rr1, e.rr2, e.wr, e.imm, e.m_sum, e.m_b, e.sub};
  endfunction

  logic [81:0] act_ctl;
  assign act_ctl = {readRegister1, readRegister2, writeRegister, immediate,
                    muxSelect_SumVsReadData, muxSelect_ImmVsDataout2, SumOrSub};

  // Presents one word at a negedge; returns 1ns after the accepting edge (E0).
  task automatic start(input logic [31:0] w);
    @(negedge clk);
    instr = w;
    instr_valid = 1'b1;
    @(posedge clk);
    #1;
    instr_valid = 1'b0;
    instr = $urandom;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    n_checks++;
    if ({instr_ready, act_ctl, writeEnable_Registers, writeEnable_DataMemory, illegalInstr, retiredCount}
        !== {1'b1, 82'd0, 2'b00, 1'b0, 32'd0})
      $display("FAIL reset_state: ready=%b ctl=%h we=%b%b ill=%b cnt=%0d required ready=1 rest 0",
               instr_ready, act_ctl, writeEnable_Registers, writeEnable_DataMemory, illegalInstr, retiredCount);
    else n_pass++;
    rst_n = 1'b1;
  endtask

  task automatic test_load_basic();
    start(32'h00003083);
    @(negedge clk);
    n_checks++;
    if ({readRegister1, writeRegister, immediate, muxSelect_SumVsReadData, muxSelect_ImmVsDataout2,
         writeEnable_Registers, instr_ready} !== {5'd0, 5'd1, 64'd0, 2'b00, 1'b0, 1'b0})
      $display("FAIL ld_decode: rr1=%0d wr=%0d imm=%h mux=%b%b weR=%b rdy=%b required 0 1 0 00 0 0",
               readRegister1, writeRegister, immediate, muxSelect_SumVsReadData,
               muxSelect_ImmVsDataout2, writeEnable_Registers, instr_ready);
    else n_pass++;
    @(negedge clk);
    n_checks++;
    if ({writeEnable_Registers, writeEnable_DataMemory} !== 2'b10)
      $display("FAIL ld_exec_we: got %b%b required 10", writeEnable_Registers, writeEnable_DataMemory);
    else n_pass++;
    @(negedge clk);
    exp_count++;
    n_checks++;
    if ({writeEnable_Registers, retiredCount, regs[1]} !== {1'b0, 32'(exp_count), 64'd8})
      $display("FAIL ld_retire: weR=%b cnt=%0d x1=%0d required 0 %0d 8",
               writeEnable_Registers, retiredCount, regs[1], exp_count);
    else n_pass++;
  endtask

  task automatic test_program();
    logic [31:0] prog [4] = '{32'h00803103, 32'h001101B3, 32'h40118233, 32'h00303C23};
    for (int i = 0; i < 4; i++) begin
      start(prog[i]);
      repeat (3) @(negedge clk);
      exp_count++;
    end
    n_checks++;
    if ({regs[1], regs[2], regs[3], regs[4], mem[3], retiredCount}
        !== {64'd8, 64'd6, 64'd14, 64'd6, 64'd14, 32'(exp_count)})
      $display("FAIL program: x1=%0d x2=%0d x3=%0d x4=%0d m3=%0d cnt=%0d required 8 6 14 6 14 %0d",
               regs[1], regs[2], regs[3], regs[4], mem[3], retiredCount, exp_count);
    else n_pass++;
  endtask

  task automatic test_neg_imm();
    start(32'hFF803283);
    @(negedge clk);
    n_checks++;
    if ({immediate, writeRegister} !== {64'hFFFFFFFFFFFFFFF8, 5'd5})
      $display("FAIL neg_imm: imm=%h wr=%0d required fffffffffffffff8 5", immediate, writeRegister);
    else n_pass++;
    repeat (2) @(negedge clk);
    exp_count++;
  endtask

  task automatic test_rd0();
    int fired = 0;
    start(32'h00208033);
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      if (writeEnable_Registers || writeEnable_DataMemory) fired++;
    end
    exp_count++;
    n_checks++;
    if ({fired, retiredCount} !== {32'd0, 32'(exp_count)})
      $display("FAIL rd0: enable_cycles=%0d cnt=%0d required 0 %0d", fired, retiredCount, exp_count);
    else n_pass++;
  endtask

  task automatic test_illegal();
    start(32'h00000013);
    @(negedge clk);
    n_checks++;
    if ({act_ctl, illegalInstr, writeEnable_Registers, writeEnable_DataMemory} !== 85'd0)
      $display("FAIL illegal_decode: ctl=%h ill=%b we=%b%b required all 0",
               act_ctl, illegalInstr, writeEnable_Registers, writeEnable_DataMemory);
    else n_pass++;
    @(negedge clk);
    exp_illegal = 1'b1;
    n_checks++;
    if ({act_ctl, illegalInstr, writeEnable_Registers, writeEnable_DataMemory} !== {82'd0, 3'b100})
      $display("FAIL illegal_exec: ctl=%h ill=%b we=%b%b required ctl 0 ill 1 we 00",
               act_ctl, illegalInstr, writeEnable_Registers, writeEnable_DataMemory);
    else n_pass++;
    @(negedge clk);
    n_checks++;
    if ({illegalInstr, retiredCount} !== {1'b1, 32'(exp_count)})
      $display("FAIL illegal_idle: ill=%b cnt=%0d required 1 %0d", illegalInstr, retiredCount, exp_count);
    else n_pass++;
    start(32'h00003083);
    @(negedge clk);
    @(negedge clk);
    n_checks++;
    if ({writeEnable_Registers, illegalInstr} !== 2'b11)
      $display("FAIL after_illegal_ld: weR=%b ill=%b required 1 1", writeEnable_Registers, illegalInstr);
    else n_pass++;
    @(negedge clk);
    exp_count++;
    n_checks++;
    if ({retiredCount, regs[1]} !== {32'(exp_count), 64'd8})
      $display("FAIL after_illegal_retire: cnt=%0d x1=%0d required %0d 8", retiredCount, regs[1], exp_count);
    else n_pass++;
  endtask

  task automatic test_ignore_valid();
    start(32'h00003303);
    instr_valid = 1'b1;
    instr = 32'h001103B3;
    @(negedge clk);
    instr = 32'h40208433;
    @(posedge clk);
    @(posedge clk);
    #1;
    instr_valid = 1'b0;
    exp_count++;
    repeat (3) @(negedge clk);
    n_checks++;
    if ({retiredCount, writeRegister, instr_ready} !== {32'(exp_count), 5'd6, 1'b1})
      $display("FAIL ignore_valid: cnt=%0d wr=%0d rdy=%b required %0d 6 1",
               retiredCount, writeRegister, instr_ready, exp_count);
    else n_pass++;
  endtask

  task automatic test_back_to_back();
    logic [31:0] words [4] = '{32'h00208433, 32'h402084B3, 32'h00003503, 32'h001085B3};
    int acc = 0;
    logic rdy;
    @(negedge clk);
    instr_valid = 1'b1;
    for (int c = 0; c < 12; c++) begin
      if (c > 0) @(negedge clk);
      instr = words[acc < 4 ? acc : 3];
      rdy = instr_ready;
      n_checks++;
      if (rdy !== (c % 3 == 0))
        $display("FAIL b2b_ready_c%0d: got %b required %b", c, rdy, (c % 3 == 0));
      else n_pass++;
      @(posedge clk);
      if (rdy) acc++;
    end
    instr_valid = 1'b0;
    exp_count += 4;
    @(negedge clk);
    n_checks++;
    if ({retiredCount, writeRegister} !== {32'(exp_count), 5'd11})
      $display("FAIL b2b_retire: cnt=%0d wr=%0d required %0d 11", retiredCount, writeRegister, exp_count);
    else n_pass++;
  endtask

  function automatic logic [31:0] rand_word();
    int unsigned k = $urandom_range(0, 4);
    logic [11:0] im = 12'($urandom);
    logic [4:0]  a = 5'($urandom), b = 5'($urandom), d = 5'($urandom);
    case (k)
      0: return {im, a, 3'(2 + $urandom_range(0, 1)), d, 7'b0000011};
      1: return {im[11:5], b, a, 3'(2 + $urandom_range(0, 1)), im[4:0], 7'b0100011};
      2: return {($urandom_range(0, 1) == 1) ? 7'b0100000 : 7'b0000000, b, a, 3'b000, d, 7'b0110011};
      3: return {7'($urandom), b, a, 3'($urandom), d, 7'b0110011};
      default: return $urandom;
    endcase
  endfunction

  task automatic test_random();
    exp_t e;
    logic [31:0] w;
    for (int i = 0; i < 40; i++) begin
      w = rand_word();
      e = model(w);
      start(w);
      @(negedge clk);
      n_checks++;
      if ({act_ctl, writeEnable_Registers, writeEnable_DataMemory, instr_ready} !== {exp_ctl(e), 3'b000})
        $display("FAIL rand_decode[%0d] w=%h: ctl=%h we=%b%b rdy=%b required ctl=%h we=00 rdy=0", i, w,
                 act_ctl, writeEnable_Registers, writeEnable_DataMemory, instr_ready, exp_ctl(e));
      else n_pass++;
      @(negedge clk);
      if (!e.legal) exp_illegal = 1'b1;
      n_checks++;
      if ({act_ctl, writeEnable_Registers, writeEnable_DataMemory, illegalInstr}
          !== {exp_ctl(e), e.we_r, e.we_m, exp_illegal})
        $display("FAIL rand_exec[%0d] w=%h: ctl=%h we=%b%b ill=%b required ctl=%h we=%b%b ill=%b", i, w,
                 act_ctl, writeEnable_Registers, writeEnable_DataMemory, illegalInstr,
                 exp_ctl(e), e.we_r, e.we_m, exp_illegal);
      else n_pass++;
      @(negedge clk);
      if (e.legal) exp_count++;
      n_checks++;
      if ({act_ctl, writeEnable_Registers, writeEnable_DataMemory, instr_ready, retiredCount}
          !== {exp_ctl(e), 3'b001, 32'(exp_count)})
        $display("FAIL rand_idle[%0d] w=%h: ctl=%h we=%b%b rdy=%b cnt=%0d required ctl=%h we=00 rdy=1 cnt=%0d",
                 i, w, act_ctl, writeEnable_Registers, writeEnable_DataMemory, instr_ready,
                 retiredCount, exp_ctl(e), exp_count);
      else n_pass++;
    end
  endtask

  task automatic test_reset_mid();
    logic [63:0] m3_before = mem[3];
    start(32'h00103C23);
    @(posedge clk);
    #2;
    n_checks++;
    if (writeEnable_DataMemory !== 1'b1)
      $display("FAIL sd_exec_we: got %b required 1", writeEnable_DataMemory);
    else n_pass++;
    rst_n = 1'b0;
    #1;
    exp_count = 0;
    exp_illegal = 1'b0;
    n_checks++;
    if ({act_ctl, writeEnable_Registers, writeEnable_DataMemory, instr_ready, illegalInstr, retiredCount}
        !== {82'd0, 3'b001, 1'b0, 32'd0})
      $display("FAIL mid_reset_clear: ctl=%h we=%b%b rdy=%b ill=%b cnt=%0d required all 0 rdy=1",
               act_ctl, writeEnable_Registers, writeEnable_DataMemory, instr_ready, illegalInstr, retiredCount);
    else n_pass++;
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    n_checks++;
    if (mem[3] !== m3_before)
      $display("FAIL mid_reset_mem: m3=%0d required %0d", mem[3], m3_before);
    else n_pass++;
    start(32'h00003083);
    repeat (3) @(negedge clk);
    exp_count++;
    n_checks++;
    if ({retiredCount, illegalInstr, regs[1]} !== {32'(exp_count), 1'b0, mem[0]})
      $display("FAIL post_reset_ld: cnt=%0d ill=%b x1=%0d required %0d 0 %0d",
               retiredCount, illegalInstr, regs[1], exp_count, mem[0]);
    else n_pass++;
  endtask

  initial begin
    test_reset();
    test_load_basic();
    test_program();
    test_neg_imm();
    test_rd0();
    test_illegal();
    test_ignore_valid();
    test_back_to_back();
    test_random();
    test_reset_mid();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/datapath_control_fsm.md
# datapath_control_fsm

Multicycle control unit that drives the 64-bit load/store/add/sub datapath (`index`). It accepts RV64 instruction words over a valid/ready handshake and decodes `ld`/`lw`, `sd`/`sw`, `add` and `sub`. For each instruction it sequences the register-file, mux, ALU and data-memory control signals that benches currently drive by hand. It replaces manual stimulus as the driver of `index` and is the first step toward a self-running core.

## Interface
Parameters:
- `COUNT_W`, 32, width of the retired-instruction counter.

Ports:
- `clk`  in  1  system clock; all state changes on rising edge.
- `rst_n`  in  1  reset, asynchronous assert, active-low.
- `instr`  in  32  RV64 instruction word; sampled when `instr_valid && instr_ready`.
- `instr_valid`  in  1  `instr` holds a valid word.
- `instr_ready`  out  1  high only in IDLE; unit can accept a word.
- `readRegister1`  out  5  rs1 to the register file.
- `readRegister2`  out  5  rs2 to the register file.
- `writeRegister`  out  5  rd to the register file.
- `immediate`  out  64  sign-extended immediate.
- `writeEnable_Registers`  out  1  register-file write strobe.
- `writeEnable_DataMemory`  out  1  data-memory write strobe.
- `muxSelect_SumVsReadData`  out  1  0 selects memory read data, 1 selects ALU sum for writeback.
- `muxSelect_ImmVsDataout2`  out  1  0 selects immediate, 1 selects dataout2 as ALU operand B.
- `SumOrSub`  out  1  0 selects add, 1 selects subtract.
- `illegalInstr`  out  1  sticky; an unsupported word was received.
- `retiredCount`  out  COUNT_W  number of legal instructions completed.

## Operation
- States: IDLE, DECODE and EXEC. Reset state is IDLE.
- IDLE: `instr_ready`=1 and both write enables are 0. Non-enable control outputs hold their last values. A handshake latches `instr` into an internal register and moves to DECODE.
- DECODE: all control outputs are driven from the latched word. Both write enables are 0. Always moves to EXEC.
- EXEC: control outputs are unchanged from DECODE. The one applicable write enable is 1 for exactly this cycle. Always moves to IDLE.
- Load: opcode 0000011, funct3 010 or 011.
  - `readRegister1`=rs1, `readRegister2`=0, `writeRegister`=rd.
  - `immediate`=sext(instr[31:20]).
  - Mux selects 0/0, `SumOrSub`=0.
  - `writeEnable_Registers`=1 in EXEC unless rd=0.
- Store: opcode 0100011, funct3 010 or 011.
  - `readRegister1`=rs1, `readRegister2`=rs2, `writeRegister`=0.
  - `immediate`=sext({instr[31:25],instr[11:7]}).
  - Mux selects 0/0, `SumOrSub`=0.
  - `writeEnable_DataMemory`=1 in EXEC.
- Add/sub: opcode 0110011, funct3 000, funct7 0000000 (add) or 0100000 (sub).
  - `readRegister1`=rs1, `readRegister2`=rs2, `writeRegister`=rd.
  - `immediate`=0.
  - Mux selects 1/1, `SumOrSub`=funct7[5].
  - `writeEnable_Registers`=1 in EXEC unless rd=0.
- Any other word is illegal:
  - Control outputs are all 0 in DECODE and EXEC, and no write enable fires.
  - `illegalInstr` sets on the DECODE→EXEC edge and stays set until reset.
  - `retiredCount` does not increment.
- `retiredCount` increments by 1 on the EXEC→IDLE edge for legal instructions, including rd=0 cases. It wraps modulo 2^COUNT_W.
- Sign extension copies the immediate's bit 11 into `immediate[63:12]`.

## Timing
- E0 is the edge at which the handshake is sampled.
  - Controls are valid from E0 to E2.
  - The write enable is high from E1 to E2.
  - The datapath commits at E2.
  - Counter and flag updates happen at E2 and E1 respectively.
- Throughput is one instruction per 3 cycles. `instr_ready` is low for the two cycles after acceptance.
- `instr_valid` without `instr_ready` is ignored. The word is not queued and `instr` may change freely.
- All outputs are registered or decoded from state only; there is no combinational path from `instr` to the outputs.
- Reset values:
  - State is IDLE and `instr_ready`=1.
  - All control outputs, `illegalInstr` and `retiredCount` are 0.
- Reset asserted mid-instruction: outputs clear immediately, no write enable pulses, and the instruction is lost. The next handshake is accepted on the first rising edge after `rst_n` rises.
- `instr_valid` held high: back-to-back words are accepted at every IDLE edge, i.e. every 3 cycles.

## Test plan
- Reset then `ld x1,0(x0)` (0x00003083):
  - In DECODE: `readRegister1`=0, `writeRegister`=1, `immediate`=0, mux selects 0/0.
  - `writeEnable_Registers`=1 for one cycle, and `retiredCount`=1 at E2.
- Against `index` with initial memory {8,6,16}, run the sequence below. Expect reg x1=8, x2=6, x3=14, x4=6 and data word 3=14.
  - `ld x2,8(x0)` (0x00803103)
  - `add x3,x2,x1` (0x001101B3)
  - `sub x4,x3,x1` (0x40118233)
  - `sd x3,24(x0)` (0x00303C23)
- `ld x5,-8(x0)` (0xFF803283) → `immediate`=0xFFFFFFFFFFFFFFF8.
- `add x0,x1,x2` (0x00208033) → no write enable in any cycle, and `retiredCount` still increments.
- Illegal word 0x00000013 → `illegalInstr`=1 from E1 and stays set, no enables, and `retiredCount` is unchanged. A following legal `ld` still executes normally.
- `rst_n` pulsed low during EXEC of `sd` → `writeEnable_DataMemory` drops immediately, and memory data word 3 is not written (no rising edge while the enable is high).
